muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT, default 40, maximum wait cycles for unit ready (2..63).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  operation request from control unit.
REQ-005 SHALL have port req_op  input  1  0 = MULT, 1 = DIV.
REQ-006 SHALL have port opa  input  32  operand A (rs), signed.
REQ-007 SHALL have port opb  input  32  operand B (rt), signed.
REQ-008 SHALL have port req_ready  output  1  high only in IDLE.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port unit_a / unit_b  output  32 each  captured operands driven to multiplier and divider.
REQ-011 SHALL have port mult_start / div_start  output  1 each  one-cycle start pulses.
REQ-012 SHALL have port mult_ready / div_ready  input  1 each  unit completion.
REQ-013 SHALL have port div_zero  input  1  divider divide-by-zero flag.
REQ-014 SHALL have port unit_hi / unit_lo  input  32 each  unit result.
REQ-015 SHALL have port hi_wr / lo_wr  output  1 each  HI/LO register write enables.
REQ-016 SHALL have port hi_data / lo_data  output  32 each  values to write into HI/LO.
REQ-017 SHALL have port done  output  1  one-cycle pulse on successful completion.
REQ-018 SHALL have port exc_div0 / exc_timeout  output  1 each  one-cycle error pulses.

Function
REQ-019 SHALL implement states IDLE, START, WAIT, WRITE, EXC.
REQ-020 IDLE: when req_valid=1, SHALL capture req_op, opa and opb.
REQ-021 From IDLE, a DIV request with opb=0 SHALL go to EXC with cause div0; every other request SHALL go to START.
REQ-022 START: SHALL assert mult_start (op=0) or div_start (op=1) for exactly one cycle, clear the wait counter, then go to WAIT.
REQ-023 WAIT: SHALL sample only the ready input of the selected unit and ignore the other unit's ready.
REQ-024 WAIT: on selected ready=1, SHALL register unit_hi and unit_lo into hi_data and lo_data, then go to WRITE.
REQ-025 WAIT, DIV only: div_zero=1 with div_ready=0 SHALL go to EXC with cause div0.
REQ-026 WAIT: the 6-bit counter SHALL increment each cycle; at counter = TIMEOUT-1 with no ready, SHALL go to EXC with cause timeout.
REQ-027 Simultaneous events in WAIT: ready SHALL win over div_zero and over timeout.
REQ-028 WRITE: SHALL assert hi_wr, lo_wr and done together for exactly one cycle, then go to IDLE.
REQ-029 EXC: SHALL pulse exactly one of exc_div0 or exc_timeout for one cycle, with hi_wr=lo_wr=done=0, then go to IDLE.
REQ-030 HI/LO SHALL never be written on an error path.
REQ-031 req_valid outside IDLE SHALL be ignored and never queued.
REQ-032 Ready inputs asserted during IDLE or START SHALL be ignored.
REQ-033 unit_a and unit_b SHALL hold the captured operands stable from START through WRITE/EXC.
REQ-034 Latency: done SHALL rise exactly 2 cycles after the WAIT cycle in which ready is sampled; minimum request-to-done latency is 4 cycles.

Reset
REQ-035 reset=1 SHALL immediately force IDLE and clear the counter, captured operands, hi_data and lo_data to 0.
REQ-036 During reset, all pulse and enable outputs SHALL be 0 and req_ready=1.
REQ-037 Reset asserted mid-operation SHALL abort with no HI/LO write and no error pulse.
REQ-038 The first request SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-039 MULT opa=7, opb=-3; mult_ready at the 5th WAIT cycle with hi=FFFFFFFF, lo=FFFFFFEB -> exactly one mult_start; hi_wr=lo_wr=done=1 for one cycle with those values; div_start never asserted.
REQ-040 DIV opa=100, opb=0 -> exc_div0 pulse 2 cycles after acceptance; no div_start; no hi_wr.
REQ-041 DIV opa=100, opb=7, div_ready never asserted, TIMEOUT=40 -> exc_timeout pulse after 40 WAIT cycles; no done.
REQ-042 div_ready and div_zero asserted together in WAIT -> WRITE path taken; done=1, exc_div0=0.
REQ-043 reset asserted during WAIT at cycle 3 -> outputs clear asynchronously; later unit ready ignored; next MULT completes normally.
REQ-044 req_valid held high for 20 cycles -> back-to-back operations; each re-accepted only when req_ready=1, no request accepted while busy.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Sequences one MULT/DIV operation: captures operands, starts the selected unit,
// waits for completion (with timeout), then writes HI/LO or raises an error pulse.
module muldiv_sequencer #(
   parameter int TIMEOUT = 40
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_op,
   input  logic [31:0] opa,
   input  logic [31:0] opb,
   output logic        req_ready,
   output logic        busy,
   output logic [31:0] unit_a,
   output logic [31:0] unit_b,
   output logic        mult_start,
   output logic        div_start,
   input  logic        mult_ready,
   input  logic        div_ready,
   input  logic        div_zero,
   input  logic [31:0] unit_hi,
   input  logic [31:0] unit_lo,
   output logic        hi_wr,
   output logic        lo_wr,
   output logic [31:0] hi_data,
   output logic [31:0] lo_data,
   output logic        done,
   output logic        exc_div0,
   output logic        exc_timeout
);

   typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_WRITE, S_EXC} state_t;

   localparam logic [5:0] CNT_LAST = 6'(TIMEOUT - 1);

   state_t      state, next_state;
   logic        op_q;
   logic [5:0]  cnt;
   logic        exc_is_tmo;
   logic        capture, load, clr_cnt, inc_cnt, go_div0, go_tmo, sel_ready;

   always_comb begin
      next_state = state;
      capture    = 1'b0;
      load       = 1'b0;
      clr_cnt    = 1'b0;
      inc_cnt    = 1'b0;
      go_div0    = 1'b0;
      go_tmo     = 1'b0;
      sel_ready  = op_q ? div_ready : mult_ready;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               capture = 1'b1;
               if (req_op && opb == 32'd0) begin
                  go_div0    = 1'b1;
                  next_state = S_EXC;
               end else begin
                  next_state = S_START;
               end
            end
         end
         S_START: begin
            clr_cnt    = 1'b1;
            next_state = S_WAIT;
         end
         S_WAIT: begin
            inc_cnt = 1'b1;
            // Completion outranks both divide-by-zero and timeout.
            if (sel_ready) begin
               load       = 1'b1;
               next_state = S_WRITE;
            end else if (op_q && div_zero) begin
               go_div0    = 1'b1;
               next_state = S_EXC;
            end else if (cnt == CNT_LAST) begin
               go_tmo     = 1'b1;
               next_state = S_EXC;
            end
         end
         S_WRITE: next_state = S_IDLE;
         S_EXC:   next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         op_q       <= 1'b0;
         unit_a     <= '0;
         unit_b     <= '0;
         cnt        <= '0;
         exc_is_tmo <= 1'b0;
         hi_data    <= '0;
         lo_data    <= '0;
      end else begin
         state <= next_state;
         if (capture) begin
            op_q   <= req_op;
            unit_a <= opa;
            unit_b <= opb;
         end
         if (clr_cnt)
            cnt <= '0;
         else if (inc_cnt)
            cnt <= cnt + 6'd1;
         if (go_div0 || go_tmo)
            exc_is_tmo <= go_tmo;
         if (load) begin
            hi_data <= unit_hi;
            lo_data <= unit_lo;
         end
      end
   end

   // Completion/error pulses are registered off the WRITE/EXC state, so they
   // appear the cycle after it (ready sampled in WAIT -> done two cycles later).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done        <= 1'b0;
         hi_wr       <= 1'b0;
         lo_wr       <= 1'b0;
         exc_div0    <= 1'b0;
         exc_timeout <= 1'b0;
      end else begin
         done        <= (state == S_WRITE);
         hi_wr       <= (state == S_WRITE);
         lo_wr       <= (state == S_WRITE);
         exc_div0    <= (state == S_EXC) && !exc_is_tmo;
         exc_timeout <= (state == S_EXC) && exc_is_tmo;
      end
   end

   assign mult_start = (state == S_START) && !op_q;
   assign div_start  = (state == S_START) && op_q;
   assign req_ready  = (state == S_IDLE);
   assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed and randomized operations
// judged against an event-time model of the operation outcome.
module tb_muldiv_sequencer;

   localparam int TMO = 40;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_op;
   logic [31:0] opa, opb;
   logic        req_ready, busy;
   logic [31:0] unit_a, unit_b;
   logic        mult_start, div_start;
   logic        mult_ready, div_ready, div_zero;
   logic [31:0] unit_hi, unit_lo;
   logic        hi_wr, lo_wr;
   logic [31:0] hi_data, lo_data;
   logic        done, exc_div0, exc_timeout;

   int checks = 0;
   int failures = 0;

   muldiv_sequencer #(.TIMEOUT(TMO)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
      .opa(opa), .opb(opb), .req_ready(req_ready), .busy(busy),
      .unit_a(unit_a), .unit_b(unit_b), .mult_start(mult_start), .div_start(div_start),
      .mult_ready(mult_ready), .div_ready(div_ready), .div_zero(div_zero),
      .unit_hi(unit_hi), .unit_lo(unit_lo), .hi_wr(hi_wr), .lo_wr(lo_wr),
      .hi_data(hi_data), .lo_data(lo_data), .done(done),
      .exc_div0(exc_div0), .exc_timeout(exc_timeout)
   );

   always #5 clk = ~clk;

   // Status vector: {mult_start, div_start, hi_wr, lo_wr, done, exc_div0, exc_timeout, req_ready, busy}
   function automatic logic [8:0] status();
      return {mult_start, div_start, hi_wr, lo_wr, done, exc_div0, exc_timeout, req_ready, busy};
   endfunction

   // One operation. Called positioned just after a rising edge; returns likewise.
   // k: WAIT cycle (1-based) in which the selected unit reports ready, 0 = never.
   // z: WAIT cycle in which div_zero is raised, 0 = never.
   task automatic run_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                         input int k, input int z, input logic [31:0] eh,
                         input logic [31:0] el, input string name);
      int  o;
      bit  ok, cdiv0, imm;
      logic [8:0] exp_st;
      imm   = op && (b == 32'd0);
      ok    = 1'b0;
      cdiv0 = 1'b0;
      // Outcome model: earliest event ends the wait; ready wins any tie.
      if (imm) begin
         o = 2; cdiv0 = 1'b1;
      end else if (k > 0 && k <= TMO && (!op || z == 0 || k <= z)) begin
         o = 3 + k; ok = 1'b1;
      end else if (op && z > 0 && z < TMO) begin
         o = 3 + z; cdiv0 = 1'b1;
      end else begin
         o = 3 + TMO;
      end
      for (int c = 0; c <= o + 1; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         req_valid = (c == 0) ? 1'b1 : ((c < o) ? 1'($urandom_range(0, 1)) : 1'b0);
         req_op    = (c == 0) ? op : 1'($urandom_range(0, 1));
         opa       = (c == 0) ? a : $urandom;
         opb       = (c == 0) ? b : $urandom;
         unit_hi   = (c == 1 + k) ? eh : $urandom;
         unit_lo   = (c == 1 + k) ? el : $urandom;
         if (op) begin
            div_ready  = (k > 0 && c == 1 + k) ? 1'b1 : ((c <= 1) ? 1'($urandom_range(0, 1)) : 1'b0);
            div_zero   = (z > 0 && c == 1 + z) ? 1'b1 : ((c <= 1) ? 1'($urandom_range(0, 1)) : 1'b0);
            mult_ready = 1'($urandom_range(0, 1));
         end else begin
            mult_ready = (k > 0 && c == 1 + k) ? 1'b1 : ((c <= 1) ? 1'($urandom_range(0, 1)) : 1'b0);
            div_ready  = 1'($urandom_range(0, 1));
            div_zero   = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
         exp_st = {(c == 1 && !op && !imm), (c == 1 && op && !imm),
                   (c == o && ok), (c == o && ok), (c == o && ok),
                   (c == o && cdiv0), (c == o && !ok && !cdiv0),
                   !(c >= 1 && c < o), (c >= 1 && c < o)};
         checks++;
         if (status() !== exp_st) begin
            failures++;
            $display("FAIL %s cyc=%0d status got=%b exp=%b", name, c, status(), exp_st);
         end
         if (c >= 1) begin
            checks++;
            if (unit_a !== a || unit_b !== b) begin
               failures++;
               $display("FAIL %s cyc=%0d operands got=%h/%h exp=%h/%h", name, c, unit_a, unit_b, a, b);
            end
         end
         if (c == o && ok) begin
            checks++;
            if (hi_data !== eh || lo_data !== el) begin
               failures++;
               $display("FAIL %s hilo got=%h/%h exp=%h/%h", name, hi_data, lo_data, eh, el);
            end
         end
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0; mult_ready = 1'b0; div_ready = 1'b0; div_zero = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 1'b1; req_op = 1'b0; opa = 32'h1234; opb = 32'h5678;
      mult_ready = 1'b1; div_ready = 1'b1; div_zero = 1'b1;
      unit_hi = 32'hAAAA; unit_lo = 32'h5555;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (status() !== 9'b0000000_10 || unit_a !== 0 || unit_b !== 0 || hi_data !== 0 || lo_data !== 0) begin
         failures++;
         $display("FAIL reset_state status=%b a=%h b=%h hi=%h lo=%h", status(), unit_a, unit_b, hi_data, lo_data);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      req_valid = 1'b0; mult_ready = 1'b0; div_ready = 1'b0; div_zero = 1'b0;
      // First request on the first edge after release.
      run_op(1'b0, 32'd11, 32'd13, 1, 0, 32'h0, 32'd143, "first_after_reset");
   endtask

   task automatic test_mult_basic();
      run_op(1'b0, 32'd7, 32'hFFFFFFFD, 5, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, "mult_7x-3");
   endtask

   task automatic test_div_by_zero_operand();
      run_op(1'b1, 32'd100, 32'd0, 3, 0, 32'h1, 32'h2, "div_opb0");
   endtask

   task automatic test_timeout();
      run_op(1'b1, 32'd100, 32'd7, 0, 0, 32'h0, 32'h0, "div_timeout");
      run_op(1'b0, 32'd5, 32'd6, 0, 0, 32'h0, 32'h0, "mult_timeout");
   endtask

   task automatic test_boundaries();
      run_op(1'b1, 32'd100, 32'd7, 3, 3, 32'd2, 32'd14, "ready_beats_zero");
      run_op(1'b1, 32'd9, 32'd2, 0, 2, 32'h0, 32'h0, "wait_div_zero");
      run_op(1'b0, 32'd3, 32'd4, TMO, 0, 32'h0, 32'd12, "ready_at_timeout");
      run_op(1'b0, 32'd3, 32'd4, 2, 1, 32'h0, 32'd12, "mult_ignores_zero");
   endtask

   task automatic test_random();
      for (int i = 0; i < 30; i++) begin
         logic        op;
         logic [31:0] b;
         int          k, z;
         op = 1'($urandom_range(0, 1));
         b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
         k  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
         z  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
         run_op(op, $urandom, b, k, z, $urandom, $urandom, "random");
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] acc_a, wait_hi;
      logic [8:0]  exp_st;
      acc_a = 32'h0; wait_hi = 32'h0;
      for (int c = 0; c < 24; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         req_valid = (c < 20); req_op = 1'b0;
         opa = $urandom; opb = $urandom;
         mult_ready = 1'b1; div_ready = 1'b0; div_zero = 1'b0;
         unit_hi = $urandom; unit_lo = $urandom;
         // Continuous requests accept every 4 cycles: IDLE, START, WAIT, WRITE.
         @(negedge clk);
         exp_st = {(c % 4 == 1 && c < 21), 1'b0, {3{c % 4 == 0 && c > 0}}, 2'b00,
                   (c % 4 == 0 || c >= 21), !(c % 4 == 0 || c >= 21)};
         checks++;
         if (status() !== exp_st) begin
            failures++;
            $display("FAIL back_to_back cyc=%0d status got=%b exp=%b", c, status(), exp_st);
         end
         if (c % 4 == 1 && c < 21) begin
            checks++;
            if (unit_a !== acc_a) begin
               failures++;
               $display("FAIL back_to_back cyc=%0d unit_a got=%h exp=%h", c, unit_a, acc_a);
            end
         end
         if (c % 4 == 0 && c > 0) begin
            checks++;
            if (hi_data !== wait_hi) begin
               failures++;
               $display("FAIL back_to_back cyc=%0d hi_data got=%h exp=%h", c, hi_data, wait_hi);
            end
         end
         if (c % 4 == 0) acc_a = opa;
         if (c % 4 == 2) wait_hi = unit_hi;
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0; mult_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c <= 4; c++) begin
         if (c > 0) begin
            @(posedge clk);
            #1;
         end
         req_valid = (c == 0); req_op = 1'b0;
         opa = 32'hCAFE; opb = 32'hBEEF;
         mult_ready = 1'b0; div_ready = 1'b0; div_zero = 1'b0;
         unit_hi = $urandom; unit_lo = $urandom;
      end
      // Cycle 4 is the third WAIT cycle: assert reset between edges.
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (status() !== 9'b0000000_10 || unit_a !== 0 || unit_b !== 0 || hi_data !== 0 || lo_data !== 0) begin
         failures++;
         $display("FAIL reset_mid status=%b a=%h b=%h hi=%h lo=%h", status(), unit_a, unit_b, hi_data, lo_data);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      mult_ready = 1'b1; div_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (status() !== 9'b0000000_10) begin
            failures++;
            $display("FAIL late_ready cyc=%0d status got=%b exp=%b", c, status(), 9'b0000000_10);
         end
         @(posedge clk);
         #1;
      end
      mult_ready = 1'b0; div_ready = 1'b0;
      run_op(1'b0, 32'd21, 32'd2, 4, 0, 32'h0, 32'd42, "mult_after_reset");
   endtask

   initial begin
      test_reset();
      test_mult_basic();
      test_div_by_zero_operand();
      test_timeout();
      test_boundaries();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
